// File: rtl/mux_scan_ctrl_pkg.sv
// Shared encodings and sizes for the dual 4:1 mux scanner.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mux_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    localparam int N_CH  = 4;
    localparam int CH_W  = 2;
    localparam int RES_W = 8;
    localparam int CNT_W = 8;

endpackage

// File: rtl/mux_scan_timer.sv
// Settle counter: expire is high on the last cycle of each channel's select window.
// Latency: expire is combinational from the count; the window is settle+1 cycles.
// Backpressure: none; load forces the count to zero, en advances it.
module mux_scan_timer
    import mux_scan_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] settle,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;

    assign expire = (cnt == settle);

    // Equality compare only: the count never runs past settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= expire ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans a dual 4:1 mux over channels 0-3, captures y1/y2 into an 8-bit word; MUX_SCAN_PARITY_EN adds a parity output.
// Latency: done pulses in the cycle after edge E0+4*(SETTLE+1), E0 being the edge that samples start.
// Backpressure: none; start is honoured only in IDLE and ignored while scanning or in DONE.
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [RES_W-1:0] data,
    output logic             a,
    output logic             b,
    output logic             gn1,
    output logic             gn2,
    input  logic             y1,
    input  logic             y2
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic             parity
`endif
);

    scan_state_t      state, state_nxt;
    logic [CH_W-1:0]  ch;
    logic [RES_W-1:0] shadow;
    logic [RES_W-1:0] capt_word;
    logic             expire;
    logic             last_ch;

    assign last_ch = (ch == CH_W'(N_CH - 1));

    mux_scan_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (state != SCAN),
        .en     (state == SCAN),
        .settle (CNT_W'(SETTLE)),
        .expire (expire)
    );

    // Shadow with the current channel's pair merged in, so the final copy includes ch3.
    always_comb begin
        capt_word = shadow;
        capt_word[{ch, 1'b0}] = y1;
        capt_word[{ch, 1'b1}] = y2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        a         = 1'b0;
        b         = 1'b0;
        gn1       = 1'b1;
        gn2       = 1'b1;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = SCAN;
            end
            SCAN: begin
                busy   = 1'b1;
                gn1    = 1'b0;
                gn2    = 1'b0;
                {b, a} = ch;
                if (expire && last_ch) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch     <= '0;
            shadow <= '0;
            data   <= '0;
        end else if (state == IDLE && start) begin
            ch <= '0;
        end else if (state == SCAN && expire) begin
            shadow <= capt_word;
            if (last_ch) begin
                data <= capt_word;
            end else begin
                ch <= ch + 1'b1;
            end
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity <= 1'b0;
        end else if (state == SCAN && expire && last_ch) begin
            parity <= ^capt_word;
        end
    end
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: SETTLE=2 and SETTLE=0 instances driven by behavioural 4:1 muxes.
// Every cycle is compared against a timeline model (scan index k since start) plus directed scenarios.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_r [2];
    logic [3:0] c1_r    [2];
    logic [3:0] c2_r    [2];
    logic       a_w     [2];
    logic       b_w     [2];
    logic       gn1_w   [2];
    logic       gn2_w   [2];
    logic       busy_w  [2];
    logic       done_w  [2];
    logic       y1_w    [2];
    logic       y2_w    [2];
    logic [7:0] data_w  [2];
`ifdef MUX_SCAN_PARITY_EN
    logic       par_w   [2];
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Timeline model state.
    logic       m_active [2];
    logic       m_done   [2];
    int         m_k      [2];
    logic [7:0] m_data   [2];

    always #5 clk = ~clk;

    mux_scan_ctrl #(.SETTLE(2)) u_dut_s2 (
        .clk(clk), .rst(rst), .start(start_r[0]), .busy(busy_w[0]), .done(done_w[0]),
        .data(data_w[0]), .a(a_w[0]), .b(b_w[0]), .gn1(gn1_w[0]), .gn2(gn2_w[0]),
        .y1(y1_w[0]), .y2(y2_w[0])
`ifdef MUX_SCAN_PARITY_EN
        , .parity(par_w[0])
`endif
    );

    mux_scan_ctrl #(.SETTLE(0)) u_dut_s0 (
        .clk(clk), .rst(rst), .start(start_r[1]), .busy(busy_w[1]), .done(done_w[1]),
        .data(data_w[1]), .a(a_w[1]), .b(b_w[1]), .gn1(gn1_w[1]), .gn2(gn2_w[1]),
        .y1(y1_w[1]), .y2(y2_w[1])
`ifdef MUX_SCAN_PARITY_EN
        , .parity(par_w[1])
`endif
    );

    // Behavioural dual 4:1 mux: a disabled half drives 0.
    assign y1_w[0] = gn1_w[0] ? 1'b0 : c1_r[0][{b_w[0], a_w[0]}];
    assign y2_w[0] = gn2_w[0] ? 1'b0 : c2_r[0][{b_w[0], a_w[0]}];
    assign y1_w[1] = gn1_w[1] ? 1'b0 : c1_r[1][{b_w[1], a_w[1]}];
    assign y2_w[1] = gn2_w[1] ? 1'b0 : c2_r[1][{b_w[1], a_w[1]}];

    function automatic int settle_of(int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic logic [7:0] interleave(logic [3:0] c1, logic [3:0] c2);
        logic [7:0] d;
        for (int k = 0; k < 4; k++) begin
            d[2*k]   = c1[k];
            d[2*k+1] = c2[k];
        end
        return d;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: k counts edges since the start was taken; the scan lasts 4*(S+1) edges.
    initial begin
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0;
            m_done[i]   = 1'b0;
            m_k[i]      = 0;
            m_data[i]   = 8'h00;
        end
        forever begin
            @(posedge clk or posedge rst);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    m_active[i] = 1'b0;
                    m_done[i]   = 1'b0;
                    m_k[i]      = 0;
                    m_data[i]   = 8'h00;
                end else if (m_active[i]) begin
                    m_k[i]++;
                    if (m_k[i] == 4 * (settle_of(i) + 1)) begin
                        m_active[i] = 1'b0;
                        m_done[i]   = 1'b1;
                        m_data[i]   = interleave(c1_r[i], c2_r[i]);
                    end
                end else if (m_done[i]) begin
                    m_done[i] = 1'b0;
                end else if (start_r[i]) begin
                    m_active[i] = 1'b1;
                    m_k[i]      = 0;
                end
            end
        end
    end

    // Cycle-by-cycle comparison, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                logic [1:0] ech;
                ech = m_active[i] ? 2'(m_k[i] / (settle_of(i) + 1)) : 2'd0;
                check($sformatf("cyc_ctl%0d", i),
                      32'({busy_w[i], done_w[i], gn2_w[i], gn1_w[i], b_w[i], a_w[i]}),
                      32'({m_active[i], m_done[i], !m_active[i], !m_active[i], ech}));
                check($sformatf("cyc_data%0d", i), 32'(data_w[i]), 32'(m_data[i]));
`ifdef MUX_SCAN_PARITY_EN
                check($sformatf("cyc_par%0d", i), 32'(par_w[i]), 32'(^m_data[i]));
`endif
            end
        end
    end

    // One scan on instance i; optional random start pulses while it is running.
    task automatic run_scan(input int i, input logic [3:0] c1, input logic [3:0] c2,
                            input bit glitch, output int lat);
        int hist [4];
        int s;
        s = settle_of(i);
        for (int j = 0; j < 4; j++) hist[j] = 0;
        @(negedge clk);
        c1_r[i]    = c1;
        c2_r[i]    = c2;
        start_r[i] = 1'b1;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        while (lat < 200) begin
            if (done_w[i]) break;
            if (busy_w[i]) hist[{b_w[i], a_w[i]}]++;
            start_r[i] = glitch ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        start_r[i] = 1'b0;
        check($sformatf("scan%0d_latency", i), 32'(lat), 32'(4 * (s + 1)));
        for (int j = 0; j < 4; j++)
            check($sformatf("scan%0d_hold_sel%0d", i, j), 32'(hist[j]), 32'(s + 1));
        check($sformatf("scan%0d_data", i), 32'(data_w[i]), 32'(interleave(c1, c2)));
    endtask

    initial begin
        int lat, nd, t, t1, t2, inst;
        start_r = '{1'b0, 1'b0};
        c1_r    = '{4'h0, 4'h0};
        c2_r    = '{4'h0, 4'h0};

        repeat (3) @(negedge clk);
        check("rst_data", 32'(data_w[0]), 32'h00);
        check("rst_ctl", 32'({busy_w[0], done_w[0], gn2_w[0], gn1_w[0], b_w[0], a_w[0]}), 32'b001100);
        rst = 1'b0;

        // Basic scans, SETTLE=2.
        run_scan(0, 4'b1010, 4'b0110, 1'b0, lat);
        run_scan(0, 4'b0110, 4'b1010, 1'b0, lat);
        check("basic_word", 32'(data_w[0]), 32'b10011100);
`ifdef MUX_SCAN_PARITY_EN
        check("parity_even", 32'(par_w[0]), 32'd0);
`endif
        run_scan(0, 4'b0111, 4'b1010, 1'b0, lat);
        check("odd_word", 32'(data_w[0]), 32'b10011101);
`ifdef MUX_SCAN_PARITY_EN
        check("parity_odd", 32'(par_w[0]), 32'd1);
`endif

        // SETTLE=0, all ones.
        run_scan(1, 4'hF, 4'hF, 1'b0, lat);
        check("s0_word", 32'(data_w[1]), 32'hFF);

        // start pulsed during SCAN and during DONE: one done only.
        @(negedge clk);
        c1_r[0] = 4'h5;
        c2_r[0] = 4'h3;
        start_r[0] = 1'b1;
        @(negedge clk);
        start_r[0] = 1'b0;
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            if (done_w[0]) nd++;
            start_r[0] = (busy_w[0] && (k % 3 == 0)) || done_w[0];
            @(negedge clk);
        end
        start_r[0] = 1'b0;
        check("ignored_start_ndone", 32'(nd), 32'd1);

        // start held high: back-to-back scans 4*(S+1)+2 cycles apart.
        @(negedge clk);
        c1_r[0] = 4'h9;
        c2_r[0] = 4'hE;
        start_r[0] = 1'b1;
        t = 0; nd = 0; t1 = 0; t2 = 0;
        while (nd < 2 && t < 100) begin
            @(negedge clk);
            t++;
            if (nd == 1 && t == t1 + 1) check("hold_idle_gap", 32'(busy_w[0]), 32'd0);
            if (nd == 1 && t == t1 + 2) check("hold_restart", 32'(busy_w[0]), 32'd1);
            if (done_w[0]) begin
                nd++;
                if (nd == 1) t1 = t;
                else t2 = t;
            end
        end
        start_r[0] = 1'b0;
        check("hold_ndone", 32'(nd), 32'd2);
        check("hold_spacing", 32'(t2 - t1), 32'd14);

        // Randomized scans on both instances, with stray start pulses.
        for (int n = 0; n < 24; n++) begin
            inst = int'($urandom_range(0, 1));
            run_scan(inst, 4'($urandom), 4'($urandom), 1'b1, lat);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Reset while scanning channel 2.
        run_scan(0, 4'hF, 4'h0, 1'b0, lat);
        @(negedge clk);
        c1_r[0] = 4'hA;
        c2_r[0] = 4'hC;
        start_r[0] = 1'b1;
        @(negedge clk);
        start_r[0] = 1'b0;
        t = 0;
        while (!(busy_w[0] && {b_w[0], a_w[0]} == 2'd2) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("midrst_reached_ch2", 32'({busy_w[0], b_w[0], a_w[0]}), 32'b110);
        #2 rst = 1'b1;
        #1;
        check("midrst_ctl", 32'({busy_w[0], done_w[0], gn2_w[0], gn1_w[0], b_w[0], a_w[0]}), 32'b001100);
        check("midrst_data", 32'(data_w[0]), 32'h00);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            if (done_w[0]) nd++;
        end
        check("midrst_no_done", 32'(nd), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
